// File: rtl/elevator_scheduler_if.sv
// elevator_scheduler_if
//   Bundles the call/timebase inputs and the car status outputs of the
//   elevator scheduler.
//   Optional build macro: ESTOP_EN (adds estop / estop_active).
// Signals
//   tick           timebase enable pulse, one clk_in cycle wide
//   req            floor-call pulses/levels, bit f = call for floor f
//   current_floor  floor the car is at or last passed
//   dir_up         1 = up preference/direction, 0 = down
//   moving         car travelling between floors
//   door_open      door dwell in progress
//   pending        latched, unserved calls
//   estop          (ESTOP_EN) emergency stop request
//   estop_active   (ESTOP_EN) registered estop
// Modports
//   master  drives tick/req, observes status (controller side / bench)
//   slave   the scheduler itself
interface elevator_scheduler_if #(
   parameter int NUM_FLOORS = 4,
   parameter int FLOOR_W    = 2
);
   logic                  tick;
   logic [NUM_FLOORS-1:0] req;
   logic [FLOOR_W-1:0]    current_floor;
   logic                  dir_up;
   logic                  moving;
   logic                  door_open;
   logic [NUM_FLOORS-1:0] pending;
`ifdef ESTOP_EN
   logic                  estop;
   logic                  estop_active;

   modport master (
      output tick, req, estop,
      input  current_floor, dir_up, moving, door_open, pending, estop_active
   );
   modport slave (
      input  tick, req, estop,
      output current_floor, dir_up, moving, door_open, pending, estop_active
   );
`else
   modport master (
      output tick, req,
      input  current_floor, dir_up, moving, door_open, pending
   );
   modport slave (
      input  tick, req,
      output current_floor, dir_up, moving, door_open, pending
   );
`endif
endinterface

// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   Car-motion sequencer: latches floor calls, chooses travel direction with
//   collective (SCAN) ordering, times floor-to-floor travel and door dwell in
//   timebase ticks.
//   Optional build macro: ESTOP_EN -- adds estop input / estop_active output
//   on the interface; while estop is high the FSM and timer hold in place
//   and calls keep latching.
// Ports
//   clk_in  system clock
//   rst     synchronous reset, active-high
//   bus     elevator_scheduler_if.slave (tick, req in; status out)
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | parked, no call to serve; decides every cycle
//   MOVE   | travelling, cnt counts ticks toward the next floor
//   DOOR   | door open at current_floor, cnt counts dwell ticks
module elevator_scheduler #(
   parameter int NUM_FLOORS   = 4,
   parameter int FLOOR_W      = 2,
   parameter int TRAVEL_TICKS = 100,
   parameter int DOOR_TICKS   = 150,
   parameter int CNT_W        = 8
) (
   input logic clk_in,
   input logic rst,
   elevator_scheduler_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

   state_t                state;
   logic [FLOOR_W-1:0]    cur_floor;
   logic                  dir_up_r;
   logic                  moving_r;
   logic                  door_r;
   logic [NUM_FLOORS-1:0] pend;
   logic [CNT_W-1:0]      cnt;

   logic                  freeze;
   logic                  above, below, here;
   logic                  nf_above, nf_below, nf_pend;
   logic                  fwd, rev, nf_fwd, nf_rev;
   logic [FLOOR_W-1:0]    nf;
   logic [NUM_FLOORS-1:0] cur_oh, nf_oh, mask_cur, clr;
   logic                  tick_ok, step_done, door_done, restart;

   localparam logic [NUM_FLOORS-1:0] ONE = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

`ifdef ESTOP_EN
   logic estop_r;
   assign freeze            = bus.estop;
   assign bus.estop_active  = estop_r;
`else
   assign freeze = 1'b0;
`endif

   assign bus.current_floor = cur_floor;
   assign bus.dir_up        = dir_up_r;
   assign bus.moving        = moving_r;
   assign bus.door_open     = door_r;
   assign bus.pending       = pend;

   // Call-position summaries relative to the current floor and to the floor
   // the car is about to reach (nf) when a travel step completes.
   always_comb begin
      above    = 1'b0;
      below    = 1'b0;
      nf_above = 1'b0;
      nf_below = 1'b0;
      nf       = dir_up_r ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (f > int'(cur_floor)) above    = above    | pend[f];
         if (f < int'(cur_floor)) below    = below    | pend[f];
         if (f > int'(nf))        nf_above = nf_above | pend[f];
         if (f < int'(nf))        nf_below = nf_below | pend[f];
      end
   end

   assign here    = pend[cur_floor];
   assign nf_pend = pend[nf];
   assign cur_oh  = ONE << cur_floor;
   assign nf_oh   = ONE << nf;
   assign fwd     = dir_up_r ? above : below;
   assign rev     = dir_up_r ? below : above;
   assign nf_fwd  = dir_up_r ? nf_above : nf_below;
   assign nf_rev  = dir_up_r ? nf_below : nf_above;

   assign tick_ok   = bus.tick & ~freeze;
   assign step_done = (state == S_MOVE) && tick_ok && (cnt == CNT_W'(TRAVEL_TICKS - 1));
   // A hall call at the open door is absorbed: it only extends the dwell.
   assign restart   = (state == S_DOOR) && bus.req[cur_floor] && !freeze;
   assign door_done = (state == S_DOOR) && tick_ok && !restart &&
                      (cnt == CNT_W'(DOOR_TICKS - 1));
   assign mask_cur  = (state == S_DOOR) ? cur_oh : '0;

   // Bit being served on this edge; it wins over a same-edge call.
   always_comb begin
      clr = '0;
      if (!freeze) begin
         if (state == S_IDLE && here)  clr = cur_oh;
         else if (step_done && nf_pend) clr = nf_oh;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= S_IDLE;
         cur_floor <= '0;
         dir_up_r  <= 1'b1;
         moving_r  <= 1'b0;
         door_r    <= 1'b0;
         pend      <= '0;
         cnt       <= '0;
`ifdef ESTOP_EN
         estop_r   <= 1'b0;
`endif
      end else begin
         pend <= (pend | (bus.req & ~mask_cur)) & ~clr;
`ifdef ESTOP_EN
         estop_r <= bus.estop;
`endif
         if (!freeze) begin
            case (state)
               S_IDLE: begin
                  if (here) begin
                     state  <= S_DOOR;
                     door_r <= 1'b1;
                     cnt    <= '0;
                  end else if (above || below) begin
                     state    <= S_MOVE;
                     moving_r <= 1'b1;
                     cnt      <= '0;
                     if (!(above && below)) dir_up_r <= above;
                  end
               end
               S_MOVE: begin
                  if (step_done) begin
                     cur_floor <= nf;
                     cnt       <= '0;
                     if (nf_pend) begin
                        state    <= S_DOOR;
                        moving_r <= 1'b0;
                        door_r   <= 1'b1;
                     end else if (nf_fwd) begin
                        state <= S_MOVE;
                     end else if (nf_rev) begin
                        dir_up_r <= ~dir_up_r;
                     end else begin
                        state    <= S_IDLE;
                        moving_r <= 1'b0;
                     end
                  end else if (bus.tick) begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               S_DOOR: begin
                  if (restart) begin
                     cnt <= '0;
                  end else if (door_done) begin
                     cnt    <= '0;
                     door_r <= 1'b0;
                     if (fwd) begin
                        state    <= S_MOVE;
                        moving_r <= 1'b1;
                     end else if (rev) begin
                        state    <= S_MOVE;
                        moving_r <= 1'b1;
                        dir_up_r <= ~dir_up_r;
                     end else begin
                        state <= S_IDLE;
                     end
                  end else if (bus.tick) begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state    <= S_IDLE;
                  moving_r <= 1'b0;
                  door_r   <= 1'b0;
               end
            endcase
         end
      end
   end

`ifndef SYNTHESIS
   // Direction logic only heads toward a pending call, so a step can never
   // leave the served range.
   always @(posedge clk_in) begin
      if (!rst && step_done)
         assert (dir_up_r ? (int'(cur_floor) < NUM_FLOORS - 1) : (cur_floor != '0));
   end
`endif

endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;
   localparam int NF = 4;
   localparam int FW = 2;
   localparam int TT = 2;
   localparam int DT = 3;

   localparam int M_IDLE = 0;
   localparam int M_MOVE = 1;
   localparam int M_DOOR = 2;

   logic clk_in = 1'b0;
   logic rst    = 1'b1;
   int   total  = 0;
   int   bad    = 0;
   bit   chk_en = 1'b0;

   elevator_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) vif ();

   elevator_scheduler #(
      .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT), .CNT_W(8)
   ) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .bus    (vif.slave)
   );

   always #5 clk_in = ~clk_in;

   // Behavioural model: the car's situation as plain integers.
   int       m_mode  = M_IDLE;
   int       m_floor = 0;
   int       m_cnt   = 0;
   bit       m_dir   = 1'b1;
   bit [3:0] m_p     = '0;

   function automatic bit calls_beyond(bit [3:0] p, int from, bit up);
      bit r = 1'b0;
      for (int f = 0; f < NF; f++)
         if ((up && f > from) || (!up && f < from)) r = r | p[f];
      return r;
   endfunction

   always @(posedge clk_in) begin : model
      bit [3:0] r;
      bit       t;
      bit [3:0] op;
      int       of, om, served, nxt;
      r = vif.req;
      t = vif.tick;
      if (rst) begin
         m_mode = M_IDLE; m_floor = 0; m_cnt = 0; m_dir = 1'b1; m_p = '0;
      end else begin
         op = m_p; of = m_floor; om = m_mode; served = -1;
         case (om)
            M_IDLE: begin
               if (op[of]) begin
                  served = of; m_mode = M_DOOR; m_cnt = 0;
               end else if (calls_beyond(op, of, 1'b1) || calls_beyond(op, of, 1'b0)) begin
                  if (!(calls_beyond(op, of, 1'b1) && calls_beyond(op, of, 1'b0)))
                     m_dir = calls_beyond(op, of, 1'b1);
                  m_mode = M_MOVE; m_cnt = 0;
               end
            end
            M_MOVE: begin
               if (t) begin
                  if (m_cnt == TT - 1) begin
                     nxt = m_dir ? of + 1 : of - 1;
                     if (nxt < 0 || nxt >= NF) begin
                        bad++;
                        $display("FAIL model_range floor=%0d required 0..%0d", nxt, NF - 1);
                        nxt = of;
                     end
                     m_floor = nxt; m_cnt = 0;
                     if (op[nxt]) begin
                        served = nxt; m_mode = M_DOOR;
                     end else if (calls_beyond(op, nxt, m_dir)) begin
                        m_mode = M_MOVE;
                     end else if (calls_beyond(op, nxt, !m_dir)) begin
                        m_dir = !m_dir;
                     end else begin
                        m_mode = M_IDLE;
                     end
                  end else m_cnt++;
               end
            end
            default: begin
               if (r[of]) m_cnt = 0;
               else if (t) begin
                  if (m_cnt == DT - 1) begin
                     m_cnt = 0;
                     if (calls_beyond(op, of, m_dir)) m_mode = M_MOVE;
                     else if (calls_beyond(op, of, !m_dir)) begin
                        m_dir = !m_dir; m_mode = M_MOVE;
                     end else m_mode = M_IDLE;
                  end else m_cnt++;
               end
            end
         endcase
         for (int f = 0; f < NF; f++) begin
            if (f == served) m_p[f] = 1'b0;
            else if (!(om == M_DOOR && f == of)) m_p[f] = m_p[f] | r[f];
         end
      end
   end

   always @(negedge clk_in) begin : compare
      if (chk_en) begin
         total++;
         if (int'(vif.current_floor) != m_floor) begin
            bad++; $display("FAIL model_floor got=%0d want=%0d t=%0t", vif.current_floor, m_floor, $time);
         end
         total++;
         if (vif.dir_up != m_dir) begin
            bad++; $display("FAIL model_dir got=%0b want=%0b t=%0t", vif.dir_up, m_dir, $time);
         end
         total++;
         if (vif.moving != (m_mode == M_MOVE)) begin
            bad++; $display("FAIL model_moving got=%0b want=%0b t=%0t", vif.moving, m_mode == M_MOVE, $time);
         end
         total++;
         if (vif.door_open != (m_mode == M_DOOR)) begin
            bad++; $display("FAIL model_door got=%0b want=%0b t=%0t", vif.door_open, m_mode == M_DOOR, $time);
         end
         total++;
         if (vif.pending != m_p) begin
            bad++; $display("FAIL model_pending got=%b want=%b t=%0t", vif.pending, m_p, $time);
         end
      end
   end

   // Apply inputs for the next edge, return at the following negedge.
   task automatic drive(input logic [3:0] r, input logic t, input logic rs);
      vif.req  = r;
      vif.tick = t;
      rst      = rs;
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
      end
   endtask

   task automatic do_reset();
      drive(4'b0000, 1'b1, 1'b1);
      drive(4'b0000, 1'b1, 1'b1);
   endtask

   initial begin
      vif.req  = '0;
      vif.tick = 1'b1;
`ifdef ESTOP_EN
      vif.estop = 1'b0;
`endif
      @(negedge clk_in);
      drive(4'b0000, 1'b1, 1'b1);
      chk_en = 1'b1;
      drive(4'b0000, 1'b1, 1'b1);

      chk("rst_floor", int'(vif.current_floor), 0);
      chk("rst_dir", int'(vif.dir_up), 1);
      chk("rst_moving", int'(vif.moving), 0);
      chk("rst_door", int'(vif.door_open), 0);
      chk("rst_pending", int'(vif.pending), 0);

      // Call to the top floor from floor 0.
      drive(4'b1000, 1'b1, 1'b0);
      for (int k = 1; k <= 11; k++) begin
         drive(4'b0000, 1'b1, 1'b0);
         case (k)
            1:  chk("up_moving_k1", int'(vif.moving), 1);
            3:  chk("up_floor_k3", int'(vif.current_floor), 1);
            5:  chk("up_floor_k5", int'(vif.current_floor), 2);
            7:  begin
                   chk("up_floor_k7", int'(vif.current_floor), 3);
                   chk("up_door_k7", int'(vif.door_open), 1);
                   chk("up_pending_k7", int'(vif.pending), 0);
                end
            9:  chk("up_door_k9", int'(vif.door_open), 1);
            10: begin
                   chk("up_door_k10", int'(vif.door_open), 0);
                   chk("up_moving_k10", int'(vif.moving), 0);
                end
            default: ;
         endcase
      end

      // Dwell restart at floor 2.
      do_reset();
      drive(4'b0100, 1'b1, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         drive((k == 8) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
         case (k)
            5:  begin
                   chk("dw_floor_k5", int'(vif.current_floor), 2);
                   chk("dw_door_k5", int'(vif.door_open), 1);
                end
            8:  chk("dw_door_k8", int'(vif.door_open), 1);
            10: chk("dw_door_k10", int'(vif.door_open), 1);
            11: begin
                   chk("dw_door_k11", int'(vif.door_open), 0);
                   chk("dw_pending_k11", int'(vif.pending), 0);
                end
            default: ;
         endcase
      end

      // Slow timebase: one tick every 4th cycle, one floor takes 8 cycles.
      do_reset();
      for (int j = 0; j <= 9; j++) begin
         drive((j == 0) ? 4'b0010 : 4'b0000, (j % 4) == 0, 1'b0);
         if (j == 7) chk("slow_floor_j7", int'(vif.current_floor), 0);
         if (j == 8) begin
            chk("slow_floor_j8", int'(vif.current_floor), 1);
            chk("slow_door_j8", int'(vif.door_open), 1);
         end
      end

      // Reset in the middle of travel.
      do_reset();
      drive(4'b1000, 1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) drive(4'b0000, 1'b1, 1'b0);
      chk("mid_floor_before", int'(vif.current_floor), 1);
      drive(4'b0000, 1'b1, 1'b1);
      chk("mid_floor_after", int'(vif.current_floor), 0);
      chk("mid_moving_after", int'(vif.moving), 0);
      chk("mid_pending_after", int'(vif.pending), 0);
      chk("mid_dir_after", int'(vif.dir_up), 1);

      // Randomized traffic against the model.
      begin
         int tick_mode;
         logic [3:0] r;
         logic t, rs;
         tick_mode = 0;
         for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) tick_mode = $urandom_range(0, 2);
            case (tick_mode)
               0:       t = 1'b1;
               1:       t = ($urandom_range(0, 1) == 0);
               default: t = ($urandom_range(0, 3) == 0);
            endcase
            r = '0;
            if ($urandom_range(0, 9) == 0) begin
               if ($urandom_range(0, 1) == 0) r = 4'(1 << $urandom_range(0, NF - 1));
               else r = 4'($urandom_range(0, 15));
            end
            rs = ($urandom_range(0, 399) == 0);
            drive(r, t, rs);
         end
      end

      drive(4'b0000, 1'b1, 1'b0);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
